data_bus_mmio: RTL and testbench
================================

// Module: data_bus_mmio
// PURPOSE
//  Downstream consumer of the pipelined core's MEM stage: decodes MemWrite/OpResult/WriteData into data RAM and MMIO registers.
//  Returns ReadData combinationally in the same cycle; the core's MEM/WB register captures it. The core has no memory stall, so every access completes in one cycle.
//  MMIO set: LEDs, synchronised switches, free-running timer, byte-wide UART transmitter.
// PARAMETERS
//  RAM_AW        7            RAM word-address width (2^RAM_AW 32-bit words)
//  CLKS_PER_BIT  868          UART bit period in CLK cycles (must be >=2)
//  MMIO_BASE     32'hFFFF_0000 MMIO window base; window = MMIO_BASE..MMIO_BASE+0xFF
// PORTS
//  CLK        in   1   clock, all state on rising edge
//  Reset_n    in   1   asynchronous active-low reset
//  MemWrite   in   1   store strobe from MEM stage
//  Addr       in   32  byte address (core OpResult); Addr[1:0] ignored, word access only
//  WriteData  in   32  store data
//  ReadData   out  32  load data, combinational from Addr
//  SW         in   16  raw switch inputs, asynchronous to CLK
//  LED        out  16  LED register
//  UART_TX    out  1   serial output, idle high
// BEHAVIOUR
//  Address decode: RAM if Addr[31:RAM_AW+2]==0; MMIO if Addr[31:8]==MMIO_BASE[31:8]; anything else unmapped.
//  Unmapped: reads return 0, writes ignored. Reads never have side effects.
//  RAM: async read; write on the rising edge when MemWrite is high and the address hits RAM. Contents undefined at reset, not cleared.
//  MMIO offsets (Addr[7:0]):
//   0x00 LED     RW  bits[15:0]; reset 0
//   0x04 SW      RO  two-flop synchroniser; a change is visible 2 cycles later; reset 0
//   0x08 TIMER   RW  32-bit, +1 every cycle, wraps 0xFFFFFFFF->0
//                    Write loads WriteData; load wins over increment; next cycle reads the written value+1.
//   0x0C UTXDATA W   byte [7:0]; reads return 0
//                    If idle: latched, transmission starts next cycle.
//                    If busy: data dropped, OVR set.
//   0x10 USTAT   RW  bit0 BUSY (RO), bit1 OVR (sticky)
//                    Writing bit1=1 clears OVR. A set and a clear in the same cycle cannot occur (different addresses).
//  UART FSM: IDLE -> START(1 bit, TX=0) -> DATA(8 bits, LSB first) -> STOP(1 bit, TX=1) -> IDLE.
//   Each state lasts CLKS_PER_BIT cycles, timed by a bit counter 0..CLKS_PER_BIT-1.
//   BUSY=1 in every state except IDLE; a frame is 10*CLKS_PER_BIT cycles.
//   BUSY drops in the cycle after the last STOP count. A new write is accepted from that cycle on.
//  Reset values: ReadData follows decode; LED=0; UART_TX=1; BUSY=0; OVR=0; TIMER=0; synchroniser=0.
//  Reset asserted mid-frame: FSM returns to IDLE and UART_TX goes high immediately (async). The frame is truncated and not resumed.
// CONFIGURATION
//  DATA_BUS_TIMER_EN defined: TIMER is implemented as described.
//  Undefined: no timer flops; offset 0x08 reads 0 and writes are ignored.
// STRUCTURE
//  Package data_bus_pkg holds:
//   - MMIO offset constants (OFS_LED, OFS_SW, OFS_TIMER, OFS_UTXDATA, OFS_USTAT)
//   - USTAT bit indices
//   - UART state encoding typedef uart_state_t (IDLE, START, DATA, STOP)
//  One sub-module, uart_tx: params CLKS_PER_BIT; ports CLK, Reset_n, start, data[7:0], busy, tx.
//  Decode, RAM, LED, SW synchroniser, TIMER and OVR stay in data_bus_mmio.
// TESTING
//  RAM: store 0xDEADBEEF to 0x14; load 0x14 and 0x17 next cycle -> both read 0xDEADBEEF; 0x18 unaffected.
//  Unmapped: store to 0x8000_0000 then load it -> 0; RAM and MMIO registers unchanged.
//  LED/SW: write 0x1234A5A5 to FFFF0000 -> LED=0xA5A5. Drive SW=0x00FF -> USTAT-independent read of FFFF0004 is 0 for 2 cycles, then 0x00FF.
//  TIMER (macro on): write 100 to FFFF0008 -> reads 101, 102 on the following cycles.
//   Free-run from 0xFFFFFFFF -> 0. With macro off: reads 0 throughout.
//  UART, CLKS_PER_BIT=4: write 0x55 to FFFF000C -> TX pattern 0,1,0,1,0,1,0,1,0,1, each 4 cycles; BUSY high exactly 40 cycles.
//   Second write while busy -> dropped and USTAT=0x3; write 0x2 to USTAT -> 0x1.
//  Reset_n pulsed low mid-frame -> UART_TX=1 and BUSY=0 without a clock edge; LED=0; TIMER=0.

Source files
------------

// File: rtl/data_bus_pkg.sv
// data_bus_pkg: shared MMIO offsets, USTAT bit indices and UART state encoding
package data_bus_pkg;
  localparam logic [7:0] OFS_LED     = 8'h00;
  localparam logic [7:0] OFS_SW      = 8'h04;
  localparam logic [7:0] OFS_TIMER   = 8'h08;
  localparam logic [7:0] OFS_UTXDATA = 8'h0C;
  localparam logic [7:0] OFS_USTAT   = 8'h10;
  localparam int USTAT_BUSY = 0;
  localparam int USTAT_OVR  = 1;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;
endpackage

// File: rtl/data_bus_mmio_uart_tx.sv
// uart_tx: byte-wide 8N1 serial transmitter, CLKS_PER_BIT clocks per bit
//   CLK, Reset_n (async active-low) | start: accept data when idle | data[7:0]: byte to send
//   busy: high in every state except IDLE | tx: serial line, idle high
module uart_tx
  import data_bus_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       CLK,
  input  logic       Reset_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       busy,
  output logic       tx
);
  localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  uart_state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [2:0] bit_idx;
  logic [7:0] data_q;
  logic last;
  assign last = cnt == CW'(CLKS_PER_BIT - 1);
  always_ff @(posedge CLK or negedge Reset_n)
    if (!Reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      data_q  <= '0;
    end else begin
      state   <= state_n;
      cnt     <= (state == IDLE || last) ? '0 : cnt + CW'(1);
      bit_idx <= state == DATA ? bit_idx + {2'b00, last} : 3'd0;
      data_q  <= (state == IDLE && start) ? data : data_q;
    end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? START : IDLE;
      START:   state_n = last ? DATA : START;
      DATA:    state_n = (last && bit_idx == 3'd7) ? STOP : DATA;
      default: state_n = last ? IDLE : STOP;
    endcase
  end
  always_comb begin
    busy = state != IDLE;
    tx   = state == START ? 1'b0 : state == DATA ? data_q[bit_idx] : 1'b1;
  end
endmodule

// File: rtl/data_bus_mmio.sv
// data_bus_mmio: MEM-stage data bus decoding into RAM and an MMIO block (LED, SW, TIMER, UART)
//   CLK, Reset_n (async active-low) | MemWrite, Addr[31:0], WriteData[31:0]: store/load request
//   ReadData[31:0]: combinational load data | SW[15:0]: async switches | LED[15:0] | UART_TX
//   Optional TIMER at offset 0x08 is built only when DATA_BUS_TIMER_EN is defined.
module data_bus_mmio
  import data_bus_pkg::*;
#(
  parameter int          RAM_AW       = 7,
  parameter int          CLKS_PER_BIT = 868,
  parameter logic [31:0] MMIO_BASE    = 32'hFFFF_0000
) (
  input  logic        CLK,
  input  logic        Reset_n,
  input  logic        MemWrite,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  input  logic [15:0] SW,
  output logic [15:0] LED,
  output logic        UART_TX
);
  logic [31:0] ram [2**RAM_AW];
  logic [RAM_AW-1:0] widx;
  logic [7:0] ofs;
  logic [15:0] sw_q1, sw_q2;
  logic ram_hit, mmio_hit, wr_led, wr_utx, wr_ustat, ovr, busy, start, unused_ok;
  assign widx      = Addr[RAM_AW+1:2];
  assign ofs       = {Addr[7:2], 2'b00};
  assign ram_hit   = Addr[31:RAM_AW+2] == '0;
  assign mmio_hit  = Addr[31:8] == MMIO_BASE[31:8];
  assign wr_led    = MemWrite && mmio_hit && ofs == OFS_LED;
  assign wr_utx    = MemWrite && mmio_hit && ofs == OFS_UTXDATA;
  assign wr_ustat  = MemWrite && mmio_hit && ofs == OFS_USTAT;
  assign start     = wr_utx && !busy;
  assign unused_ok = ^Addr[1:0];
  always_ff @(posedge CLK)
    if (MemWrite && ram_hit) ram[widx] <= WriteData;
  always_ff @(posedge CLK or negedge Reset_n)
    if (!Reset_n) begin
      LED   <= '0;
      sw_q1 <= '0;
      sw_q2 <= '0;
      ovr   <= 1'b0;
    end else begin
      LED   <= wr_led ? WriteData[15:0] : LED;
      sw_q1 <= SW;
      sw_q2 <= sw_q1;
      ovr   <= (wr_utx && busy) ? 1'b1 : (wr_ustat && WriteData[USTAT_OVR]) ? 1'b0 : ovr;
    end
`ifdef DATA_BUS_TIMER_EN
  logic [31:0] timer;
  logic wr_timer;
  assign wr_timer = MemWrite && mmio_hit && ofs == OFS_TIMER;
  always_ff @(posedge CLK or negedge Reset_n)
    if (!Reset_n) timer <= '0;
    else timer <= wr_timer ? WriteData + 32'd1 : timer + 32'd1;
`endif
  always_comb begin
    ReadData = '0;
    if (ram_hit) ReadData = ram[widx];
    else if (mmio_hit)
      case (ofs)
        OFS_LED:   ReadData = {16'h0, LED};
        OFS_SW:    ReadData = {16'h0, sw_q2};
`ifdef DATA_BUS_TIMER_EN
        OFS_TIMER: ReadData = timer;
`endif
        OFS_USTAT: begin
          ReadData[USTAT_BUSY] = busy;
          ReadData[USTAT_OVR]  = ovr;
        end
        default:   ReadData = '0;
      endcase
  end
  uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .CLK(CLK),
    .Reset_n(Reset_n),
    .start(start),
    .data(WriteData[7:0]),
    .busy(busy),
    .tx(UART_TX)
  );
endmodule

// File: tb/tb_data_bus_mmio.sv
// tb_data_bus_mmio: table, directed and randomized checks of data_bus_mmio
module tb_data_bus_mmio;
  localparam int CPB = 4;
  localparam logic [31:0] MB = 32'hFFFF_0000;
`ifdef DATA_BUS_TIMER_EN
  localparam bit TEN = 1'b1;
`else
  localparam bit TEN = 1'b0;
`endif
  typedef struct {
    bit          we;
    logic [31:0] a;
    logic [31:0] wd;
    bit          chk;
    logic [31:0] exp;
    logic [15:0] led;
  } vec_t;
  logic CLK = 1'b0, Reset_n = 1'b0, MemWrite = 1'b0, UART_TX;
  logic [31:0] Addr = '0, WriteData = '0, ReadData;
  logic [15:0] SW = '0, LED;
  int total = 0, bad = 0;
  vec_t vt[$];
  logic [31:0] mem[int];
  data_bus_mmio #(.RAM_AW(7), .CLKS_PER_BIT(CPB), .MMIO_BASE(MB)) dut (
    .CLK(CLK), .Reset_n(Reset_n), .MemWrite(MemWrite), .Addr(Addr), .WriteData(WriteData),
    .ReadData(ReadData), .SW(SW), .LED(LED), .UART_TX(UART_TX)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask
  task automatic drive(input bit we, input logic [31:0] a, input logic [31:0] wd);
    MemWrite = we;
    Addr = a;
    WriteData = wd;
  endtask
  function automatic logic tx_bit(input logic [7:0] d, input int t);
    int b;
    b = t / CPB;
    return b == 0 ? 1'b0 : b <= 8 ? d[b-1] : 1'b1;
  endfunction
  initial begin
    logic [15:0] led_m, s0, s1, s2;
    logic [7:0] dm;
    logic ovr_m, busy_m;
    int ts, nts;
    vt.push_back(vec_t'{1'b1, 32'h0000_0000, 32'h0BAD_F00D, 1'b0, 32'h0, 16'h0});
    vt.push_back(vec_t'{1'b1, 32'h0000_0018, 32'h0000_1111, 1'b0, 32'h0, 16'h0});
    vt.push_back(vec_t'{1'b1, 32'h0000_0014, 32'hDEAD_BEEF, 1'b0, 32'h0, 16'h0});
    vt.push_back(vec_t'{1'b0, 32'h0000_0014, 32'h0, 1'b1, 32'hDEAD_BEEF, 16'h0});
    vt.push_back(vec_t'{1'b0, 32'h0000_0017, 32'h0, 1'b1, 32'hDEAD_BEEF, 16'h0});
    vt.push_back(vec_t'{1'b0, 32'h0000_0018, 32'h0, 1'b1, 32'h0000_1111, 16'h0});
    vt.push_back(vec_t'{1'b1, 32'h8000_0000, 32'hCAFE_F00D, 1'b0, 32'h0, 16'h0});
    vt.push_back(vec_t'{1'b0, 32'h8000_0000, 32'h0, 1'b1, 32'h0, 16'h0});
    vt.push_back(vec_t'{1'b0, 32'h0000_0000, 32'h0, 1'b1, 32'h0BAD_F00D, 16'h0});
    vt.push_back(vec_t'{1'b0, 32'h0000_0014, 32'h0, 1'b1, 32'hDEAD_BEEF, 16'h0});
    vt.push_back(vec_t'{1'b0, 32'h0000_0200, 32'h0, 1'b1, 32'h0, 16'h0});
    vt.push_back(vec_t'{1'b1, MB, 32'h1234_A5A5, 1'b0, 32'h0, 16'h0});
    vt.push_back(vec_t'{1'b0, MB, 32'h0, 1'b1, 32'h0000_A5A5, 16'hA5A5});
    vt.push_back(vec_t'{1'b0, MB + 32'h2, 32'h0, 1'b1, 32'h0000_A5A5, 16'hA5A5});
    vt.push_back(vec_t'{1'b0, MB + 32'hC, 32'h0, 1'b1, 32'h0, 16'hA5A5});
    vt.push_back(vec_t'{1'b0, MB + 32'h10, 32'h0, 1'b1, 32'h0, 16'hA5A5});
    vt.push_back(vec_t'{1'b0, MB + 32'h14, 32'h0, 1'b1, 32'h0, 16'hA5A5});
    vt.push_back(vec_t'{1'b0, MB + 32'h100, 32'h0, 1'b1, 32'h0, 16'hA5A5});
    vt.push_back(vec_t'{1'b1, 32'h8000_0000, 32'h0000_0000, 1'b0, 32'h0, 16'hA5A5});
    vt.push_back(vec_t'{1'b0, MB, 32'h0, 1'b1, 32'h0000_A5A5, 16'hA5A5});
    vt.push_back(vec_t'{1'b1, 32'h0000_01FC, 32'h1357_9BDF, 1'b0, 32'h0, 16'hA5A5});
    vt.push_back(vec_t'{1'b0, 32'h0000_01FD, 32'h0, 1'b1, 32'h1357_9BDF, 16'hA5A5});
    drive(0, MB + 32'h10, 0);
    #3;
    chk("rst_tx", {31'h0, UART_TX}, 32'h1);
    chk("rst_led_port", {16'h0, LED}, 32'h0);
    chk("rst_ustat", ReadData, 32'h0);
    Addr = MB;
    #1;
    chk("rst_led_read", ReadData, 32'h0);
    tick;
    tick;
    Reset_n = 1'b1;
    foreach (vt[i]) begin
      drive(vt[i].we, vt[i].a, vt[i].wd);
      #3;
      if (vt[i].chk) chk($sformatf("vec%0d_rd", i), ReadData, vt[i].exp);
      chk($sformatf("vec%0d_led", i), {16'h0, LED}, {16'h0, vt[i].led});
      tick;
    end
    drive(0, MB + 32'h4, 0);
    SW = 16'h00FF;
    #3;
    chk("sw_c0", ReadData, 32'h0);
    tick;
    #3;
    chk("sw_c1", ReadData, 32'h0);
    tick;
    #3;
    chk("sw_c2", ReadData, 32'h00FF);
    tick;
    drive(1, MB + 32'h8, 32'd100);
    tick;
    drive(0, MB + 32'h8, 0);
    #3;
    chk("timer_ld1", ReadData, TEN ? 32'd101 : 32'd0);
    tick;
    #3;
    chk("timer_ld2", ReadData, TEN ? 32'd102 : 32'd0);
    tick;
    drive(1, MB + 32'h8, 32'hFFFF_FFFE);
    tick;
    drive(0, MB + 32'h8, 0);
    #3;
    chk("timer_max", ReadData, TEN ? 32'hFFFF_FFFF : 32'd0);
    tick;
    #3;
    chk("timer_wrap", ReadData, 32'd0);
    tick;
    #3;
    chk("timer_after_wrap", ReadData, TEN ? 32'd1 : 32'd0);
    tick;
    led_m = 16'hA5A5;
    mem[127] = 32'h1357_9BDF;
    s0 = SW;
    s1 = SW;
    s2 = SW;
    for (int i = 0; i < 300; i++) begin
      int op, idx;
      logic [31:0] a, wd;
      s2 = s1;
      s1 = s0;
      if ($urandom_range(3) == 0) SW = 16'($urandom);
      s0 = SW;
      op = $urandom_range(4);
      idx = $urandom_range(8) == 8 ? 127 : 32 + int'($urandom_range(7));
      a = 32'(idx * 4) + 32'($urandom_range(3));
      wd = $urandom;
      if (op == 0) drive(1, a, wd);
      else if (op == 1) drive(0, a, 0);
      else if (op == 2) drive(1, MB, wd);
      else if (op == 3) drive(0, MB, 0);
      else drive(0, MB + 32'h4, 0);
      #3;
      chk("rnd_led_port", {16'h0, LED}, {16'h0, led_m});
      if (op == 1 && mem.exists(idx)) chk("rnd_ram", ReadData, mem[idx]);
      if (op == 3) chk("rnd_led_rd", ReadData, {16'h0, led_m});
      if (op == 4) chk("rnd_sw", ReadData, {16'h0, s2});
      if (op == 0) mem[idx] = wd;
      if (op == 2) led_m = wd[15:0];
      tick;
    end
    ts = -1;
    dm = 8'h0;
    ovr_m = 1'b0;
    for (int k = 0; k < 56; k++) begin
      if (k == 0) drive(1, MB + 32'hC, 32'h55);
      else if (k == 6) drive(1, MB + 32'hC, 32'hAA);
      else if (k == 8) drive(1, MB + 32'h10, 32'h2);
      else if (k == 41) drive(1, MB + 32'hC, 32'hC3);
      else drive(0, MB + 32'h10, 0);
      busy_m = ts >= 0 && ts < 10 * CPB;
      #3;
      chk($sformatf("uart_tx_k%0d", k), {31'h0, UART_TX}, {31'h0, busy_m ? tx_bit(dm, ts) : 1'b1});
      if (!MemWrite) chk($sformatf("ustat_k%0d", k), ReadData, {30'h0, ovr_m, busy_m});
      nts = ts < 0 ? -1 : ts + 1;
      if (MemWrite && Addr == MB + 32'hC && !busy_m) begin
        dm = WriteData[7:0];
        nts = 0;
      end
      if (MemWrite && Addr == MB + 32'hC && busy_m) ovr_m = 1'b1;
      if (MemWrite && Addr == MB + 32'h10 && WriteData[1]) ovr_m = 1'b0;
      ts = nts;
      tick;
    end
    drive(0, MB + 32'h10, 0);
    #2;
    Reset_n = 1'b0;
    #1;
    chk("midrst_tx", {31'h0, UART_TX}, 32'h1);
    chk("midrst_ustat", ReadData, 32'h0);
    chk("midrst_led_port", {16'h0, LED}, 32'h0);
    Addr = MB + 32'h8;
    #1;
    chk("midrst_timer", ReadData, 32'h0);
    tick;
    Reset_n = 1'b1;
    drive(0, MB + 32'h10, 0);
    for (int k = 0; k < 12; k++) begin
      #3;
      chk("post_rst_tx", {31'h0, UART_TX}, 32'h1);
      chk("post_rst_ustat", ReadData, 32'h0);
      tick;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
